// File: rtl/egress_port_shaper.sv
// Per-port egress stage: registered AXI4-Stream toward the MAC with a token-bucket gate on
// packet heads, PIFO sideband discarded, and per-packet byte/packet statistics.
module egress_port_shaper #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int PIFO_INFO_LENGTH   = 68,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TOKEN_WIDTH        = 24
) (
    input  logic                              axis_aclk,
    input  logic                              axis_resetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic [PIFO_INFO_LENGTH-1:0]       s_axis_tpifo,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    input  logic                              cfg_shaper_en,
    input  logic [15:0]                       cfg_rate,
    input  logic [TOKEN_WIDTH-1:0]            cfg_bucket_max,

    output logic [C_S_AXI_DATA_WIDTH-1:0]     bytes_removed,
    output logic                              pkt_removed,
    output logic                              shaper_blocked
);

    localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(KEEP_W + 1);
    localparam int TW     = TOKEN_WIDTH + 1;
    localparam int AW     = TOKEN_WIDTH + 3;
    localparam logic signed [AW-1:0] TOK_MIN = {{(AW-TOKEN_WIDTH){1'b1}}, {TOKEN_WIDTH{1'b0}}};

    typedef enum logic {
        HEAD,
        BODY
    } state_t;

    state_t state_q, state_d;

    logic                          rdy_q;
    logic signed [TW-1:0]          tokens_q, tokens_d;
    logic                          gate_open;
    logic                          in_fire;
    logic                          head_fire;
    logic                          out_fire;

    logic                          skid_valid;
    logic [C_AXIS_DATA_WIDTH-1:0]  skid_tdata;
    logic [KEEP_W-1:0]             skid_tkeep;
    logic [C_AXIS_TUSER_WIDTH-1:0] skid_tuser;
    logic                          skid_tlast;

    logic [CNT_W-1:0]              beat_bytes;
    logic [C_S_AXI_DATA_WIDTH-1:0] byte_acc;

    logic signed [AW-1:0]          t_ext, rate_ext, cap_ext, len_ext;
    logic signed [AW-1:0]          t_fill, t_cap, t_next;

    logic                          unused_pifo;

    assign unused_pifo = ^s_axis_tpifo;

    function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // rdy_q keeps s_axis_tready low through reset and for the release cycle.
    assign gate_open      = (state_q == BODY) || !cfg_shaper_en || !tokens_q[TW-1];
    assign s_axis_tready  = rdy_q && gate_open && !skid_valid;
    assign in_fire        = s_axis_tvalid && s_axis_tready;
    assign head_fire      = in_fire && (state_q == HEAD);
    assign out_fire       = m_axis_tvalid && m_axis_tready;
    assign shaper_blocked = (state_q == HEAD) && s_axis_tvalid && cfg_shaper_en && tokens_q[TW-1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            HEAD:    if (in_fire && !s_axis_tlast) state_d = BODY;
            BODY:    if (in_fire && s_axis_tlast)  state_d = HEAD;
            default: state_d = HEAD;
        endcase
    end

    // Refill, clamp to the ceiling, then deduct; computed two bits wider so nothing wraps.
    always_comb begin
        t_ext    = {{(AW-TW){tokens_q[TW-1]}}, tokens_q};
        rate_ext = {{(AW-16){1'b0}}, cfg_rate};
        cap_ext  = {{(AW-TOKEN_WIDTH){1'b0}}, cfg_bucket_max};
        len_ext  = {{(AW-16){1'b0}}, s_axis_tuser[15:0]};
        t_fill   = t_ext + rate_ext;
        t_cap    = (t_fill > cap_ext) ? cap_ext : t_fill;
        t_next   = (head_fire && cfg_shaper_en) ? (t_cap - len_ext) : t_cap;
        if (t_next < TOK_MIN) begin
            t_next = TOK_MIN;
        end
        tokens_d = t_next[TW-1:0];
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q  <= HEAD;
            tokens_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tokens_q <= tokens_d;
            rdy_q    <= 1'b1;
        end
    end

    // Output register plus one skid entry; s_axis_tready only sees the registered skid flag.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            skid_valid    <= 1'b0;
            skid_tdata    <= '0;
            skid_tkeep    <= '0;
            skid_tuser    <= '0;
            skid_tlast    <= 1'b0;
        end else if (!m_axis_tvalid || m_axis_tready) begin
            if (skid_valid) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= skid_tdata;
                m_axis_tkeep  <= skid_tkeep;
                m_axis_tuser  <= skid_tuser;
                m_axis_tlast  <= skid_tlast;
                skid_valid    <= 1'b0;
            end else begin
                m_axis_tvalid <= in_fire;
                if (in_fire) begin
                    m_axis_tdata <= s_axis_tdata;
                    m_axis_tkeep <= s_axis_tkeep;
                    m_axis_tuser <= s_axis_tuser;
                    m_axis_tlast <= s_axis_tlast;
                end
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_tdata <= s_axis_tdata;
            skid_tkeep <= s_axis_tkeep;
            skid_tuser <= s_axis_tuser;
            skid_tlast <= s_axis_tlast;
        end
    end

    assign beat_bytes = popcount(m_axis_tkeep);

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            byte_acc      <= '0;
            bytes_removed <= '0;
            pkt_removed   <= 1'b0;
        end else begin
            pkt_removed <= 1'b0;
            if (out_fire) begin
                if (m_axis_tlast) begin
                    bytes_removed <= byte_acc + C_S_AXI_DATA_WIDTH'(beat_bytes);
                    byte_acc      <= '0;
                    pkt_removed   <= 1'b1;
                end else begin
                    byte_acc <= byte_acc + C_S_AXI_DATA_WIDTH'(beat_bytes);
                end
            end
        end
    end

endmodule

// File: tb/tb_egress_port_shaper.sv
// Bench for egress_port_shaper: directed scenarios plus randomized packets, all checked each
// cycle against a queue/integer reference model of the stream, token bucket and statistics.
module tb_egress_port_shaper;

    localparam int DW = 256;
    localparam int KW = DW / 8;
    localparam int UW = 128;
    localparam int PW = 68;
    localparam int SW = 32;
    localparam int TKW = 24;

    logic            clk = 1'b0;
    logic            axis_resetn = 1'b1;
    logic [DW-1:0]   s_axis_tdata = '0;
    logic [KW-1:0]   s_axis_tkeep = '0;
    logic [UW-1:0]   s_axis_tuser = '0;
    logic [PW-1:0]   s_axis_tpifo = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tlast = 1'b0;
    logic            s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready = 1'b1;
    logic            cfg_shaper_en = 1'b0;
    logic [15:0]     cfg_rate = '0;
    logic [TKW-1:0]  cfg_bucket_max = '0;
    logic [SW-1:0]   bytes_removed;
    logic            pkt_removed;
    logic            shaper_blocked;

    always #5 clk = ~clk;

    egress_port_shaper #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .PIFO_INFO_LENGTH  (PW),
        .C_S_AXI_DATA_WIDTH(SW),
        .TOKEN_WIDTH       (TKW)
    ) dut (
        .axis_aclk     (clk),
        .axis_resetn   (axis_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tpifo  (s_axis_tpifo),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .cfg_shaper_en (cfg_shaper_en),
        .cfg_rate      (cfg_rate),
        .cfg_bucket_max(cfg_bucket_max),
        .bytes_removed (bytes_removed),
        .pkt_removed   (pkt_removed),
        .shaper_blocked(shaper_blocked)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state (updated at each falling edge, predicting the next rising edge)
    beat_t exp_q[$];
    int    tok = 0;
    bit    m_head = 1'b1;
    bit    m_started = 1'b0;
    int    acc = 0;
    int    exp_bytes = 0;
    bit    exp_pkt = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t prev_out;
    int    cyc = 0;

    // Observation counters used by directed scenarios
    int    in_first_cyc = -1;
    int    out_first_cyc = -1;
    int    out_last_cyc = -1;
    int    out_fire_cnt = 0;
    int    pkt_cnt = 0;
    int    blocked_cnt = 0;
    int    head_cycs[$];
    int    rdy_mode = 0;

    always @(negedge clk) begin : monitor
        beat_t b;
        bit    gate;
        bit    nxt_pkt;
        cyc++;
        if (!axis_resetn) begin
            chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
            chk("rst_s_tready", s_axis_tready, 1'b0);
            chk("rst_pkt_removed", pkt_removed, 1'b0);
            chk("rst_shaper_blocked", shaper_blocked, 1'b0);
            exp_q.delete();
            tok = 0; m_head = 1'b1; m_started = 1'b0;
            acc = 0; exp_bytes = 0; exp_pkt = 1'b0; prev_stall = 1'b0;
        end else begin
            gate = !m_head || !cfg_shaper_en || (tok >= 0);
            chk("m_tvalid", m_axis_tvalid, exp_q.size() > 0);
            chk("s_tready", s_axis_tready, m_started && gate && (exp_q.size() < 2));
            chk("shaper_blocked", shaper_blocked, m_head && s_axis_tvalid && cfg_shaper_en && (tok < 0));
            chk("pkt_removed", pkt_removed, exp_pkt);
            chk("bytes_removed", bytes_removed, SW'(exp_bytes));
            if (prev_stall) begin
                chk("stall_tdata", m_axis_tdata, prev_out.data);
                chk("stall_tkeep", m_axis_tkeep, prev_out.keep);
                chk("stall_tuser", m_axis_tuser, prev_out.user);
                chk("stall_tlast", m_axis_tlast, prev_out.last);
            end
            if (pkt_removed) pkt_cnt++;
            if (shaper_blocked) blocked_cnt++;

            nxt_pkt = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", m_axis_tvalid, 1'b0);
                end else begin
                    b = exp_q.pop_front();
                    chk("out_tdata", m_axis_tdata, b.data);
                    chk("out_tkeep", m_axis_tkeep, b.keep);
                    chk("out_tuser", m_axis_tuser, b.user);
                    chk("out_tlast", m_axis_tlast, b.last);
                    acc += $countones(b.keep);
                    if (b.last) begin
                        exp_bytes = acc;
                        acc = 0;
                        nxt_pkt = 1'b1;
                    end
                end
                out_fire_cnt++;
                if (out_first_cyc < 0) out_first_cyc = cyc;
                out_last_cyc = cyc;
            end
            exp_pkt = nxt_pkt;

            tok = tok + int'(cfg_rate);
            if (tok > int'(cfg_bucket_max)) tok = int'(cfg_bucket_max);
            if (s_axis_tvalid && s_axis_tready) begin
                b.data = s_axis_tdata;
                b.keep = s_axis_tkeep;
                b.user = s_axis_tuser;
                b.last = s_axis_tlast;
                exp_q.push_back(b);
                if (in_first_cyc < 0) in_first_cyc = cyc;
                if (m_head) begin
                    head_cycs.push_back(cyc);
                    if (cfg_shaper_en) tok = tok - int'(s_axis_tuser[15:0]);
                end
                m_head = s_axis_tlast;
            end
            if (tok < -(1 << TKW)) tok = -(1 << TKW);

            m_started = 1'b1;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_out.data = m_axis_tdata;
            prev_out.keep = m_axis_tkeep;
            prev_out.user = m_axis_tuser;
            prev_out.last = m_axis_tlast;
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_beat(input logic [KW-1:0] keep, input logic last, input logic [UW-1:0] user);
        for (int w = 0; w < DW / 32; w++) s_axis_tdata[w*32 +: 32] = $urandom;
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tpifo  = PW'({$urandom, $urandom, $urandom});
        s_axis_tvalid = 1'b1;
    endtask

    task automatic send_pkt(input int nbeats, input logic [KW-1:0] last_keep, input int len_ovr);
        int len;
        int waited;
        logic [UW-1:0] u;
        len = (len_ovr >= 0) ? len_ovr : (nbeats - 1) * KW + $countones(last_keep);
        u = {$urandom, $urandom, $urandom, $urandom};
        u[15:0] = 16'(len);
        for (int b = 0; b < nbeats; b++) begin
            drive_beat((b == nbeats - 1) ? last_keep : '1, b == nbeats - 1, u);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!s_axis_tready && waited < 2000);
            if (!s_axis_tready) begin
                chk("handshake_timeout", s_axis_tready, 1'b1);
                s_axis_tvalid = 1'b0;
                s_axis_tlast = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        axis_resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        axis_resetn = 1'b1;
    endtask

    task automatic clear_marks();
        in_first_cyc = -1; out_first_cyc = -1; out_last_cyc = -1;
        out_fire_cnt = 0; pkt_cnt = 0; blocked_cnt = 0;
        head_cycs.delete();
    endtask

    initial begin : stimulus
        int gap;
        int nb;
        logic [KW-1:0] lk;
        logic [UW-1:0] u;

        // Reset values, asynchronous
        #2 axis_resetn = 1'b0;
        #1;
        chk("reset_m_tvalid", m_axis_tvalid, 1'b0);
        chk("reset_m_tdata", m_axis_tdata, '0);
        chk("reset_m_tkeep", m_axis_tkeep, '0);
        chk("reset_m_tuser", m_axis_tuser, '0);
        chk("reset_m_tlast", m_axis_tlast, 1'b0);
        chk("reset_s_tready", s_axis_tready, 1'b0);
        chk("reset_bytes_removed", bytes_removed, '0);
        chk("reset_pkt_removed", pkt_removed, 1'b0);
        chk("reset_shaper_blocked", shaper_blocked, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        axis_resetn = 1'b1;
        #1;
        chk("tready_before_first_edge", s_axis_tready, 1'b0);
        @(posedge clk); #1;
        chk("tready_after_first_edge", s_axis_tready, 1'b1);

        // Shaping disabled: 10 back-to-back 64 B packets
        clear_marks();
        for (int i = 0; i < 10; i++) send_pkt(2, '1, -1);
        drain();
        chk("dis_out_beats", out_fire_cnt, 20);
        chk("dis_no_bubbles", out_last_cyc - out_first_cyc, 19);
        chk("dis_first_latency", out_first_cyc - in_first_cyc, 1);
        chk("dis_pkt_pulses", pkt_cnt, 10);
        chk("dis_bytes", bytes_removed, 64);

        // Rate limiting: rate 1, two 64 B packets
        cfg_shaper_en = 1'b1; cfg_rate = 16'd1; cfg_bucket_max = 24'd1000;
        do_reset();
        clear_marks();
        send_pkt(2, '1, -1);
        send_pkt(2, '1, -1);
        drain();
        chk("rate_heads", head_cycs.size(), 2);
        if (head_cycs.size() >= 2) begin
            gap = head_cycs[1] - head_cycs[0];
            chk("rate_gap_in_63_65", (gap >= 63) && (gap <= 65), 1'b1);
        end
        chk("rate_blocked_seen", blocked_cnt >= 55, 1'b1);

        // Backpressure: toggling m_axis_tready during a 5-beat packet
        cfg_shaper_en = 1'b0;
        clear_marks();
        rdy_mode = 1;
        send_pkt(5, '1, -1);
        drain();
        rdy_mode = 0;
        chk("bp_out_beats", out_fire_cnt, 5);
        chk("bp_bytes", bytes_removed, 160);

        // Partial last beat
        clear_marks();
        send_pkt(3, 32'h0000_00FF, -1);
        drain();
        chk("partial_bytes", bytes_removed, 72);
        chk("partial_pkt_pulses", pkt_cnt, 1);

        // Bucket clamp: refill to 500, then a 1500 B head drives tokens to -1000
        cfg_shaper_en = 1'b1; cfg_rate = 16'd100; cfg_bucket_max = 24'd500;
        repeat (20) @(posedge clk);
        #1;
        clear_marks();
        send_pkt(1, '1, 1500);
        send_pkt(1, '1, 64);
        drain();
        chk("clamp_heads", head_cycs.size(), 2);
        if (head_cycs.size() >= 2) chk("clamp_gap", head_cycs[1] - head_cycs[0], 11);

        // Reset mid-packet, then shaped traffic must start from HEAD
        cfg_rate = 16'd4; cfg_bucket_max = 24'd1000;
        u = '0;
        u[15:0] = 16'd128;
        drive_beat('1, 1'b0, u);
        @(negedge clk);
        chk("mid_beat1_ready", s_axis_tready, 1'b1);
        @(posedge clk); #1;
        drive_beat('1, 1'b0, u);
        chk("mid_pre_reset_tvalid", m_axis_tvalid, 1'b1);
        axis_resetn = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("mid_rst_m_tdata", m_axis_tdata, '0);
        chk("mid_rst_m_tkeep", m_axis_tkeep, '0);
        chk("mid_rst_m_tlast", m_axis_tlast, 1'b0);
        chk("mid_rst_s_tready", s_axis_tready, 1'b0);
        chk("mid_rst_bytes", bytes_removed, '0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        axis_resetn = 1'b1;
        clear_marks();
        send_pkt(2, '1, -1);
        send_pkt(2, '1, -1);
        drain();
        chk("mid_after_beats", out_fire_cnt, 4);
        chk("mid_after_bytes", bytes_removed, 64);
        chk("mid_after_blocked", blocked_cnt > 0, 1'b1);

        // Randomized traffic with random configuration and backpressure
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) begin
                cfg_shaper_en  = 1'($urandom_range(0, 1));
                cfg_rate       = 16'($urandom_range(4, 64));
                cfg_bucket_max = 24'($urandom_range(100, 3000));
                rdy_mode       = $urandom_range(0, 2);
            end
            nb = $urandom_range(1, 4);
            lk = 32'hFFFF_FFFF >> $urandom_range(0, 31);
            send_pkt(nb, lk, -1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
